// File: rtl/mipi_csi_pkg.sv
// Shared constants and types for the CSI-2 2-lane packet decoder.
// Combinational helpers only; no latency and no backpressure of its own.
package mipi_csi_pkg;

   localparam logic [7:0] SYNC_BYTE   = 8'hB8;

   localparam logic [5:0] DT_LONG_MIN = 6'h10;
   localparam logic [5:0] DT_YUV422_8 = 6'h1E;
   localparam logic [5:0] DT_RGB565   = 6'h22;
   localparam logic [5:0] DT_RGB888   = 6'h24;
   localparam logic [5:0] DT_RAW8     = 6'h2A;
   localparam logic [5:0] DT_RAW10    = 6'h2B;
   localparam logic [5:0] DT_RAW12    = 6'h2C;
   localparam logic [5:0] DT_RAW14    = 6'h2D;

   typedef enum logic [2:0] {
      PT_NONE     = 3'd0,
      PT_RAW8     = 3'd1,
      PT_RAW10    = 3'd2,
      PT_RAW12    = 3'd3,
      PT_RAW14    = 3'd4,
      PT_YUV422_8 = 3'd5,
      PT_RGB565   = 3'd6,
      PT_RGB888   = 3'd7
   } pkt_type_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR0,
      ST_HDR1,
      ST_PAYLOAD,
      ST_SKIP
   } state_e;

   function automatic pkt_type_e dt_to_type(input logic [5:0] dt);
      pkt_type_e t;
      case (dt)
         DT_RAW8:     t = PT_RAW8;
         DT_RAW10:    t = PT_RAW10;
         DT_RAW12:    t = PT_RAW12;
         DT_RAW14:    t = PT_RAW14;
         DT_YUV422_8: t = PT_YUV422_8;
         DT_RGB565:   t = PT_RGB565;
         DT_RGB888:   t = PT_RGB888;
         default:     t = PT_NONE;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/csi_header_ecc.sv
// CSI-2 packet header ECC: 6 parity bits over {WC[15:0], DI[7:0]}.
// Purely combinational, zero latency, no backpressure.
module csi_header_ecc (
   input  logic [23:0] hdr_i,
   output logic [5:0]  ecc_o
);

   // Each mask selects the header bits covered by one parity bit.
   localparam logic [23:0] M0 = 24'hF12CB7;
   localparam logic [23:0] M1 = 24'hF2555B;
   localparam logic [23:0] M2 = 24'h749A6D;
   localparam logic [23:0] M3 = 24'hB8E38E;
   localparam logic [23:0] M4 = 24'hDF03F0;
   localparam logic [23:0] M5 = 24'hEFFC00;

   always_comb begin
      ecc_o[0] = ^(hdr_i & M0);
      ecc_o[1] = ^(hdr_i & M1);
      ecc_o[2] = ^(hdr_i & M2);
      ecc_o[3] = ^(hdr_i & M3);
      ecc_o[4] = ^(hdr_i & M4);
      ecc_o[5] = ^(hdr_i & M5);
   end

endmodule

// File: rtl/mipi_csi_rx_packet_decoder_8b2l.sv
// CSI-2 2-lane packet decoder: sync detect, header parse, long-packet payload forward.
// Payload out 1 cycle after sampling; no backpressure, data_valid_i low aborts the packet.
// Optional CSI_PKT_DEC_ECC_CHECK_EN: header ECC mismatch routes the packet to SKIP.
module mipi_csi_rx_packet_decoder_8b2l
   import mipi_csi_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE_P = SYNC_BYTE,
   parameter int         LANES       = 2
) (
   input  logic                 clk_i,
   input  logic                 reset_n_i,
   input  logic                 data_valid_i,
   input  logic [LANES*8-1:0]   data_i,
   output logic                 output_valid_o,
   output logic [LANES*8-1:0]   data_o,
   output logic [15:0]          packet_length_o,
   output logic [2:0]           packet_type_o
);

   localparam int W = LANES * 8;

   state_e           state_q, state_d;
   logic [7:0]       di_q, di_d;
   logic [7:0]       wc_lo_q, wc_lo_d;
   logic [15:0]      cnt_q, cnt_d;
   logic [15:0]      len_q, len_d;
   pkt_type_e        type_q, type_d;
   logic             out_vld_q, out_vld_d;
   logic [W-1:0]     out_dat_q, out_dat_d;

   logic [15:0]      hdr_wc;
   logic [15:0]      cnt_dec;
   logic             hdr_ok;
   pkt_type_e        hdr_type;

   assign hdr_wc  = {data_i[7:0], wc_lo_q};
   assign cnt_dec = (cnt_q > 16'd2) ? (cnt_q - 16'd2) : 16'd0;

`ifdef CSI_PKT_DEC_ECC_CHECK_EN
   logic [5:0] ecc_calc;

   csi_header_ecc u_ecc (
      .hdr_i ({hdr_wc, di_q}),
      .ecc_o (ecc_calc)
   );

   assign hdr_ok = (ecc_calc == data_i[13:8]);
`else
   logic unused_vc;
   assign unused_vc = &{1'b0, di_q[7:6]};
   assign hdr_ok    = 1'b1;
`endif

   always_comb begin
      state_d   = state_q;
      di_d      = di_q;
      wc_lo_d   = wc_lo_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      type_d    = type_q;
      out_vld_d = 1'b0;
      out_dat_d = out_dat_q;
      hdr_type  = hdr_ok ? dt_to_type(di_q[5:0]) : PT_NONE;

      if (state_q == ST_IDLE) begin
         if (data_valid_i && data_i == {SYNC_BYTE_P, SYNC_BYTE_P}) begin
            state_d = ST_HDR0;
         end
      end else if (!data_valid_i) begin
         // Lanes dropped to LP mid-packet: abandon it, keep the reported header.
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_HDR0: begin
               di_d    = data_i[7:0];
               wc_lo_d = data_i[15:8];
               state_d = ST_HDR1;
            end
            ST_HDR1: begin
               if (di_q[5:0] < DT_LONG_MIN) begin
                  state_d = ST_IDLE;
               end else begin
                  len_d  = hdr_wc;
                  type_d = hdr_type;
                  cnt_d  = hdr_wc;
                  if (hdr_wc == 16'd0) begin
                     state_d = ST_IDLE;
                  end else if (hdr_type != PT_NONE) begin
                     state_d = ST_PAYLOAD;
                  end else begin
                     state_d = ST_SKIP;
                  end
               end
            end
            ST_PAYLOAD: begin
               out_vld_d = 1'b1;
               out_dat_d = data_i;
               cnt_d     = cnt_dec;
               if (cnt_dec == 16'd0) begin
                  state_d = ST_IDLE;
               end
            end
            ST_SKIP: begin
               cnt_d = cnt_dec;
               if (cnt_dec == 16'd0) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= ST_IDLE;
         di_q      <= 8'd0;
         wc_lo_q   <= 8'd0;
         cnt_q     <= 16'd0;
         len_q     <= 16'd0;
         type_q    <= PT_NONE;
         out_vld_q <= 1'b0;
         out_dat_q <= '0;
      end else begin
         state_q   <= state_d;
         di_q      <= di_d;
         wc_lo_q   <= wc_lo_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         type_q    <= type_d;
         out_vld_q <= out_vld_d;
         out_dat_q <= out_dat_d;
      end
   end

   assign output_valid_o  = out_vld_q;
   assign data_o          = out_dat_q;
   assign packet_length_o = len_q;
   assign packet_type_o   = type_q;

endmodule

// File: tb/tb_mipi_csi_rx_packet_decoder_8b2l.sv
// Directed + randomized bench for the CSI-2 packet decoder, default build (ECC check off).
module tb_mipi_csi_rx_packet_decoder_8b2l;

   logic        clk_i = 1'b0;
   logic        reset_n_i = 1'b0;
   logic        data_valid_i = 1'b0;
   logic [15:0] data_i = 16'h0;
   logic        output_valid_o;
   logic [15:0] data_o;
   logic [15:0] packet_length_o;
   logic [2:0]  packet_type_o;

   int errors = 0;
   int checks = 0;

   logic [15:0] pay[$];
   logic [15:0] obs[$];
   logic [15:0] expq[$];
   logic [15:0] exp_len = 16'h0;
   logic [2:0]  exp_type = 3'h0;
   int          code_of[int];

   mipi_csi_rx_packet_decoder_8b2l dut (
      .clk_i           (clk_i),
      .reset_n_i       (reset_n_i),
      .data_valid_i    (data_valid_i),
      .data_i          (data_i),
      .output_valid_o  (output_valid_o),
      .data_o          (data_o),
      .packet_length_o (packet_length_o),
      .packet_type_o   (packet_type_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (reset_n_i && output_valid_o) obs.push_back(data_o);
   end

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic drive(input logic v, input logic [15:0] d);
      @(negedge clk_i);
      data_valid_i = v;
      data_i       = d;
   endtask

   function automatic logic [15:0] rnd_word();
      logic [15:0] w;
      w = 16'($urandom);
      if (w == 16'hB8B8) w = 16'hB8B9;
      return w;
   endfunction

   function automatic logic [2:0] code(input logic [7:0] di);
      int k;
      k = int'(di[5:0]);
      return code_of.exists(k) ? 3'(code_of[k]) : 3'd0;
   endfunction

   // Sends sync + header + pay[], optionally drops valid after pay[], then trailing junk.
   task automatic send_pkt(input logic [7:0] di, input logic [15:0] wc, input bit drop, input string tag);
      int need;
      obs.delete();
      expq.delete();
      if (di[5:0] >= 6'h10) begin
         exp_len  = wc;
         exp_type = code(di);
         if (exp_type != 3'd0) begin
            need = (int'(wc) + 1) / 2;
            for (int i = 0; i < pay.size() && i < need; i++) expq.push_back(pay[i]);
         end
      end
      drive(1'b1, 16'hB8B8);
      drive(1'b1, {wc[7:0], di});
      drive(1'b1, {8'($urandom), wc[15:8]});
      foreach (pay[i]) drive(1'b1, pay[i]);
      if (drop) drive(1'b0, rnd_word());
      drive(1'b1, rnd_word());
      drive(1'b1, rnd_word());
      drive(1'b0, rnd_word());
      repeat (3) @(negedge clk_i);
      chk({tag, ".count"}, obs.size(), expq.size());
      for (int i = 0; i < expq.size() && i < obs.size(); i++)
         chk($sformatf("%s.word%0d", tag, i), obs[i], expq[i]);
      chk({tag, ".len"}, packet_length_o, exp_len);
      chk({tag, ".type"}, packet_type_o, exp_type);
   endtask

   task automatic rand_pay(input int n);
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back(rnd_word());
   endtask

   initial begin
      logic [7:0] dis[12];
      logic [7:0] di;
      logic [15:0] wc;

      code_of[32'h2A] = 1; code_of[32'h2B] = 2; code_of[32'h2C] = 3; code_of[32'h2D] = 4;
      code_of[32'h1E] = 5; code_of[32'h22] = 6; code_of[32'h24] = 7;
      dis = '{8'h2A, 8'h2B, 8'h2C, 8'h2D, 8'h1E, 8'h22, 8'h24, 8'h12, 8'h30, 8'h01, 8'h0F, 8'h10};

      #1;
      chk("rst.vld", output_valid_o, 0);
      chk("rst.dat", data_o, 0);
      chk("rst.len", packet_length_o, 0);
      chk("rst.type", packet_type_o, 0);
      repeat (2) @(negedge clk_i);
      reset_n_i = 1'b1;

      // Lanes idle with garbage on the bus, including a sync pattern.
      obs.delete();
      drive(1'b0, 16'hB8B8);
      drive(1'b0, 16'h062B);
      for (int i = 0; i < 4; i++) drive(1'b0, 16'($urandom));
      repeat (2) @(negedge clk_i);
      chk("idle.count", obs.size(), 0);
      chk("idle.dat", data_o, 0);
      chk("idle.len", packet_length_o, 0);
      chk("idle.type", packet_type_o, 0);

      // Reference RAW10 packet, preceded by zero words in IDLE.
      drive(1'b1, 16'h0000);
      drive(1'b1, 16'h0000);
      pay = '{16'hFFEE, 16'h3322, 16'h0FA0};
      send_pkt(8'h2B, 16'd6, 1'b0, "raw10");
      chk("raw10.hold", data_o, 16'h0FA0);

      rand_pay(3);
      send_pkt(8'h12, 16'd6, 1'b0, "unsup");
      rand_pay(4);
      send_pkt(8'h2A, 16'd8, 1'b0, "after_unsup");

      rand_pay(4);
      send_pkt(8'h24, 16'd5, 1'b0, "odd_wc");

      rand_pay(1);
      send_pkt(8'h2C, 16'h0260, 1'b1, "drop");

      rand_pay(2);
      send_pkt(8'h01, 16'd4, 1'b0, "short");

      rand_pay(2);
      send_pkt(8'h22, 16'd0, 1'b0, "wc0");

      for (int n = 0; n < 12; n++) begin
         di = dis[$urandom_range(0, 11)];
         di[7:6] = 2'($urandom);
         wc = 16'($urandom_range(0, 24));
         rand_pay((int'(wc) + 1) / 2 + int'($urandom_range(0, 2)));
         send_pkt(di, wc, 1'b0, $sformatf("rnd%0d", n));
      end

      // Reset in the middle of a payload burst.
      drive(1'b1, 16'hB8B8);
      drive(1'b1, 16'h142A);
      drive(1'b1, 16'h5500);
      drive(1'b1, 16'h1234);
      drive(1'b1, 16'h5678);
      drive(1'b1, 16'h9ABC);
      @(posedge clk_i);
      #2;
      chk("midrst.pre_vld", output_valid_o, 1);
      reset_n_i = 1'b0;
      #1;
      chk("midrst.vld", output_valid_o, 0);
      chk("midrst.dat", data_o, 0);
      chk("midrst.len", packet_length_o, 0);
      chk("midrst.type", packet_type_o, 0);
      exp_len  = 16'h0;
      exp_type = 3'h0;
      drive(1'b0, 16'h0);
      @(negedge clk_i);
      reset_n_i = 1'b1;
      rand_pay(2);
      send_pkt(8'h2D, 16'd4, 1'b0, "post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
